// File: rtl/model_math_verilog_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// model_math_verilog_pkg : shared constants and per-element hyperbolic evaluator
// Rev 1.0
// ---------------------------------------------------------------------------
package model_math_verilog_pkg;

    localparam logic [63:0] ZERO_DATA       = 64'h0000_0000_0000_0000;
    localparam logic [63:0] MAX_DOUBLE_DATA = 64'h7FEF_FFFF_FFFF_FFFF;

    localparam logic [1:0] SINH_MODE = 2'd0;
    localparam logic [1:0] COSH_MODE = 2'd1;
    localparam logic [1:0] TANH_MODE = 2'd2;
    localparam logic [1:0] EXP_MODE  = 2'd3;

    typedef struct packed {
        logic [63:0] data;
        logic        overflow;
    } hyperbolic_result_t;

    function automatic hyperbolic_result_t hyperbolic_eval(input logic [1:0] mode, input real operand);
        real                r;
        logic [63:0]        bits;
        hyperbolic_result_t res;
        r = 0.0;
        case (mode)
            SINH_MODE: r = $sinh(operand);
            COSH_MODE: r = $cosh(operand);
            TANH_MODE: r = $tanh(operand);
            default:   r = $exp(operand);
        endcase
        bits = $realtobits(r);
        // All-ones exponent means inf or NaN; NaN saturates to the positive maximum
        if (bits[62:52] == 11'h7FF) begin
            res.overflow = 1'b1;
            if (bits[51:0] == 52'd0 && bits[63])
                res.data = {1'b1, MAX_DOUBLE_DATA[62:0]};
            else
                res.data = MAX_DOUBLE_DATA;
        end else begin
            res.overflow = 1'b0;
            res.data     = bits;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/model_vector_hyperbolic_function.sv
`default_nettype none
// ---------------------------------------------------------------------------
// model_vector_hyperbolic_function : element-wise sinh/cosh/tanh/exp over a vector
// Rev 1.0
// ---------------------------------------------------------------------------
module model_vector_hyperbolic_function
    import model_math_verilog_pkg::*;
#(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    input  logic [1:0]           MODE,
    input  logic [DATA_SIZE-1:0] SIZE_IN,
    input  logic                 DATA_IN_ENABLE,
    output logic                 DATA_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_IN,
    output logic                 DATA_OUT_ENABLE,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 OVERFLOW_OUT
);

    if (DATA_SIZE != 64 || CONTROL_SIZE < 0) begin : g_param_check
        $error("model_vector_hyperbolic_function: DATA_SIZE must be 64");
    end

    localparam logic [1:0] STARTER_STATE = 2'd0;
    localparam logic [1:0] INPUT_STATE   = 2'd1;
    localparam logic [1:0] ENDER_STATE   = 2'd2;

    localparam logic [DATA_SIZE-1:0] ONE_VALUE = {{(DATA_SIZE-1){1'b0}}, 1'b1};

    logic [1:0]           state_q,   state_d;
    logic [1:0]           mode_q,    mode_d;
    logic [DATA_SIZE-1:0] size_q,    size_d;
    logic [DATA_SIZE-1:0] index_q,   index_d;
    logic [DATA_SIZE-1:0] operand_q, operand_d;
    logic                 ready_q,   ready_d;
    logic                 de_q,      de_d;
    logic                 doe_q,     doe_d;
    logic [DATA_SIZE-1:0] dout_q,    dout_d;
    logic                 ovf_q,     ovf_d;

    hyperbolic_result_t   w_eval;

    assign w_eval = hyperbolic_eval(mode_q, $bitstoreal(operand_q));

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        size_d    = size_q;
        index_d   = index_q;
        operand_d = operand_q;
        ready_d   = ready_q;
        de_d      = de_q;
        doe_d     = doe_q;
        dout_d    = dout_q;
        ovf_d     = ovf_q;
        case (state_q)
            STARTER_STATE: begin
                ready_d = 1'b0;
                doe_d   = 1'b0;
                // A START overlapping the READY cycle belongs to the finished run
                if (START && !ready_q) begin
                    mode_d  = MODE;
                    size_d  = SIZE_IN;
                    index_d = '0;
                    if (SIZE_IN == '0) begin
                        ready_d = 1'b1;
                    end else begin
                        de_d    = 1'b1;
                        state_d = INPUT_STATE;
                    end
                end
            end
            INPUT_STATE: begin
                doe_d = 1'b0;
                de_d  = 1'b1;
                if (DATA_IN_ENABLE) begin
                    operand_d = DATA_IN;
                    de_d      = 1'b0;
                    state_d   = ENDER_STATE;
                end
            end
            ENDER_STATE: begin
                dout_d = w_eval.data;
                ovf_d  = w_eval.overflow;
                doe_d  = 1'b1;
                if (index_q == size_q - ONE_VALUE) begin
                    ready_d = 1'b1;
                    state_d = STARTER_STATE;
                end else begin
                    index_d = index_q + ONE_VALUE;
                    de_d    = 1'b1;
                    state_d = INPUT_STATE;
                end
            end
            default: begin
                state_d = STARTER_STATE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= STARTER_STATE;
            mode_q    <= SINH_MODE;
            size_q    <= '0;
            index_q   <= '0;
            operand_q <= '0;
            ready_q   <= 1'b0;
            de_q      <= 1'b0;
            doe_q     <= 1'b0;
            dout_q    <= ZERO_DATA;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            size_q    <= size_d;
            index_q   <= index_d;
            operand_q <= operand_d;
            ready_q   <= ready_d;
            de_q      <= de_d;
            doe_q     <= doe_d;
            dout_q    <= dout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign READY           = ready_q;
    assign DATA_ENABLE     = de_q;
    assign DATA_OUT_ENABLE = doe_q;
    assign DATA_OUT        = dout_q;
    assign OVERFLOW_OUT    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_model_vector_hyperbolic_function.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_model_vector_hyperbolic_function : scoreboard bench with directed vectors
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_model_vector_hyperbolic_function;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        READY;
    logic [1:0]  MODE = 2'd0;
    logic [63:0] SIZE_IN = 64'd0;
    logic        DATA_IN_ENABLE = 1'b0;
    logic        DATA_ENABLE;
    logic [63:0] DATA_IN = 64'd0;
    logic        DATA_OUT_ENABLE;
    logic [63:0] DATA_OUT;
    logic        OVERFLOW_OUT;

    model_vector_hyperbolic_function #(.DATA_SIZE(64), .CONTROL_SIZE(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .MODE(MODE),
        .SIZE_IN(SIZE_IN), .DATA_IN_ENABLE(DATA_IN_ENABLE), .DATA_ENABLE(DATA_ENABLE),
        .DATA_IN(DATA_IN), .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_OUT(DATA_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        logic        last;
        int          gap;
    } exp_t;

    exp_t sb[$];
    exp_t vexp[$];
    real  vin[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int last_cyc = 0;
    int zero_ready_exp = 0;

    localparam logic [63:0] POS_MAX = 64'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG_MAX = 64'hFFEF_FFFF_FFFF_FFFF;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic exp_t model(input logic [1:0] m, input real x, input logic last, input int gap);
        real   r;
        exp_t  e;
        logic [63:0] b;
        case (m)
            2'd0:    r = $sinh(x);
            2'd1:    r = $cosh(x);
            2'd2:    r = $tanh(x);
            default: r = $exp(x);
        endcase
        b = $realtobits(r);
        e.last = last;
        e.gap  = gap;
        if (b[62:52] == 11'h7FF) begin
            e.ovf  = 1'b1;
            e.data = (b[51:0] == 52'd0 && b[63]) ? NEG_MAX : POS_MAX;
        end else begin
            e.ovf  = 1'b0;
            e.data = b;
        end
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] d, input logic o, input logic last, input int gap);
        exp_t e;
        e.data = d; e.ovf = o; e.last = last; e.gap = gap;
        return e;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: every output pulse is matched against the head of the scoreboard
    always @(negedge CLK) begin
        if (DATA_OUT_ENABLE) begin
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data_out", DATA_OUT, e.data);
                chk("overflow_out", {63'd0, OVERFLOW_OUT}, {63'd0, e.ovf});
                chk("ready_with_pulse", {63'd0, READY}, {63'd0, e.last});
                if (e.gap != 0)
                    chk("pulse_spacing", 64'(cyc - last_cyc), 64'(e.gap));
            end
            last_cyc = cyc;
        end else if (READY) begin
            if (zero_ready_exp == 0) begin
                chk("unexpected_ready", 64'd1, 64'd0);
            end else begin
                zero_ready_exp--;
                checks++;
                passes++;
            end
        end
    end

    task automatic start_run(input logic [1:0] m, input logic [63:0] n);
        @(posedge CLK); #1;
        START = 1'b1; MODE = m; SIZE_IN = n;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic wait_de();
        int n = 0;
        while (!DATA_ENABLE && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!DATA_ENABLE) chk("data_enable_timeout", 64'd0, 64'd1);
    endtask

    task automatic feed(input bit hold);
        for (int i = 0; i < vin.size(); i++) begin
            wait_de();
            DATA_IN_ENABLE = 1'b1;
            DATA_IN = $realtobits(vin[i]);
            sb.push_back(vexp[i]);
            @(posedge CLK); #1;
            if (!hold) DATA_IN_ENABLE = 1'b0;
        end
        DATA_IN_ENABLE = 1'b0;
        vin.delete();
        vexp.delete();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(posedge CLK);
            n++;
        end
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, READY}, 64'd0);
        chk({tag, "_data_enable"}, {63'd0, DATA_ENABLE}, 64'd0);
        chk({tag, "_data_out_enable"}, {63'd0, DATA_OUT_ENABLE}, 64'd0);
        chk({tag, "_data_out"}, DATA_OUT, 64'd0);
        chk({tag, "_overflow"}, {63'd0, OVERFLOW_OUT}, 64'd0);
    endtask

    initial begin
        real xs[3];
        xs[0] = 0.0; xs[1] = 0.5; xs[2] = -2.0;

        repeat (3) @(posedge CLK);
        #1;
        chk_reset_outputs("reset_init");
        @(negedge CLK);
        RST = 1'b1;

        // sinh(1.0), single element
        start_run(2'd0, 64'd1);
        vin.push_back(1.0);
        vexp.push_back(mk(64'h3FF2_CD9F_C44E_B982, 1'b0, 1'b1, 0));
        feed(1'b0);
        drain();

        // cosh/tanh/exp over three elements at full throughput
        for (int m = 1; m <= 3; m++) begin
            start_run(2'(m), 64'd3);
            for (int i = 0; i < 3; i++) begin
                vin.push_back(xs[i]);
                if (m == 1 && i == 0)
                    vexp.push_back(mk(64'h3FF0_0000_0000_0000, 1'b0, 1'b0, 0));
                else
                    vexp.push_back(model(2'(m), xs[i], i == 2, (i == 0) ? 0 : 2));
            end
            feed(1'b1);
            drain();
        end

        // Saturation both ways, then a clean element clears the flag
        start_run(2'd3, 64'd1);
        vin.push_back(710.0);
        vexp.push_back(mk(POS_MAX, 1'b1, 1'b1, 0));
        feed(1'b0);
        drain();
        start_run(2'd0, 64'd2);
        vin.push_back(-800.0);
        vexp.push_back(mk(NEG_MAX, 1'b1, 1'b0, 0));
        vin.push_back(0.0);
        vexp.push_back(mk(64'd0, 1'b0, 1'b1, 0));
        feed(1'b0);
        drain();

        // Empty vector
        zero_ready_exp++;
        start_run(2'd2, 64'd0);
        chk("size0_ready", {63'd0, READY}, 64'd1);
        chk("size0_data_enable", {63'd0, DATA_ENABLE}, 64'd0);
        @(posedge CLK); #1;
        chk("size0_ready_drop", {63'd0, READY}, 64'd0);
        drain();

        // Ignored inputs: DATA_IN_ENABLE while idle, START/MODE during a run
        DATA_IN_ENABLE = 1'b1;
        DATA_IN = $realtobits(3.0);
        repeat (3) @(posedge CLK);
        #1;
        chk("idle_data_enable", {63'd0, DATA_ENABLE}, 64'd0);
        DATA_IN_ENABLE = 1'b0;
        start_run(2'd1, 64'd2);
        vin.push_back(0.5);
        vexp.push_back(model(2'd1, 0.5, 1'b0, 0));
        vin.push_back(1.0);
        vexp.push_back(model(2'd1, 1.0, 1'b1, 2));
        fork
            feed(1'b1);
            begin
                @(posedge CLK);
                #2;
                START = 1'b1;
                MODE  = 2'd3;
                SIZE_IN = 64'd7;
                repeat (2) @(posedge CLK);
                #2;
                START = 1'b0;
            end
        join
        drain();

        // Asynchronous reset in the middle of element index 2
        start_run(2'd2, 64'd4);
        vin.push_back(0.25);
        vexp.push_back(model(2'd2, 0.25, 1'b0, 0));
        vin.push_back(0.75);
        vexp.push_back(model(2'd2, 0.75, 1'b0, 0));
        feed(1'b0);
        wait_de();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk_reset_outputs("reset_midrun");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        start_run(2'd3, 64'd1);
        vin.push_back(1.0);
        vexp.push_back(model(2'd3, 1.0, 1'b1, 0));
        feed(1'b0);
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("size0_ready_seen", 64'(zero_ready_exp), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/model_vector_hyperbolic_function.md
# model_vector_hyperbolic_function

Vector hyperbolic function unit for the NTM math model layer. It evaluates sinh, cosh, tanh or exp element by element over a run of SIZE_IN IEEE-754 double operands. Each element is requested and accepted through the vector element handshake, and overflow saturates per element. It sits in the math/series vector model set, feeding activation and controller models that need hyperbolic series results on whole vectors.

## Interface
- DATA_SIZE, 64, operand/result width; must be 64 (IEEE double), any other value is an elaboration error
- CONTROL_SIZE, 4, kept for uniformity with sibling blocks; unused
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  reset; asynchronous, active-low (one clock, RST low forces reset immediately)
- START  in  1  begin a run; sampled only in STARTER_STATE
- READY  out  1  one-cycle pulse when the run completes
- MODE  in  2  function: 0 sinh, 1 cosh, 2 tanh, 3 exp; latched on accepted START
- SIZE_IN  in  DATA_SIZE  element count; latched on accepted START
- DATA_IN_ENABLE  in  1  DATA_IN valid for the current element
- DATA_ENABLE  out  1  block is waiting for the next element
- DATA_IN  in  DATA_SIZE  element operand (double bits)
- DATA_OUT_ENABLE  out  1  one-cycle pulse, DATA_OUT/OVERFLOW_OUT valid
- DATA_OUT  out  DATA_SIZE  element result (double bits)
- OVERFLOW_OUT  out  1  current element saturated

## Operation
- States: STARTER_STATE, INPUT_STATE, ENDER_STATE.
- STARTER_STATE:
  - READY <= 0; DATA_OUT_ENABLE <= 0.
  - On START=1: latch MODE and SIZE_IN, index <= 0.
  - If SIZE_IN == 0: READY <= 1 and stay in STARTER_STATE. No element is requested.
  - Otherwise: DATA_ENABLE <= 1, go to INPUT_STATE.
- INPUT_STATE:
  - DATA_OUT_ENABLE <= 0; DATA_ENABLE is held 1 while waiting.
  - On DATA_IN_ENABLE=1: operand <= $bitstoreal(DATA_IN), DATA_ENABLE <= 0, go to ENDER_STATE.
- ENDER_STATE:
  - Compute r = f_mode(operand) with $sinh/$cosh/$tanh/$exp.
  - If r is ±inf or NaN: DATA_OUT <= sign(r)·max finite double (0x7FEFFFFFFFFFFFFF or 0xFFEFFFFFFFFFFFFF; NaN uses the positive value) and OVERFLOW_OUT <= 1.
  - Else: DATA_OUT <= $realtobits(r) and OVERFLOW_OUT <= 0.
  - DATA_OUT_ENABLE <= 1.
  - If index == SIZE_IN-1: READY <= 1, go to STARTER_STATE.
  - Else: index <= index+1, DATA_ENABLE <= 1, go to INPUT_STATE.
- Ignored inputs:
  - START outside STARTER_STATE.
  - DATA_IN_ENABLE outside INPUT_STATE.
  - MODE and SIZE_IN changes mid-run.
- DATA_OUT and OVERFLOW_OUT hold their last values between pulses.
- Undefined state encoding: return to STARTER_STATE, no output change.

## Timing
- Reset values: READY 0, DATA_ENABLE 0, DATA_OUT_ENABLE 0, DATA_OUT ZERO_DATA, OVERFLOW_OUT 0, state STARTER_STATE, index 0.
- Reset mid-run aborts the run with no READY pulse.
- START accepted at edge k → DATA_ENABLE high after edge k.
- DATA_IN_ENABLE sampled at edge m → DATA_OUT_ENABLE and DATA_OUT valid for exactly one cycle after edge m+1.
- Maximum throughput is one element per 2 cycles, with DATA_IN_ENABLE held high.
- Last element: READY and its DATA_OUT_ENABLE are asserted in the same cycle.
- Next START is accepted no earlier than the edge after READY deasserts.
- SIZE_IN == 0: READY is high one cycle after the START edge.

## Structure
- Shared package model_math_verilog_pkg holds:
  - ZERO_DATA and MAX_DOUBLE_DATA (0x7FEFFFFFFFFFFFFF);
  - mode encodings SINH_MODE=0, COSH_MODE=1, TANH_MODE=2, EXP_MODE=3;
  - function hyperbolic_eval(mode, real), returning the bits plus the overflow flag.
- State parameters are local to the module.
- Sub-module: none. The per-element evaluation is the package function, shared with a future matrix variant.

## Test plan
- Reset: RST low mid-run, INPUT_STATE with index 2 → all outputs at reset values immediately; a fresh START afterwards runs normally.
- MODE=0, SIZE_IN=1, DATA_IN=1.0 (0x3FF0000000000000) → one DATA_OUT_ENABLE pulse, DATA_OUT == $realtobits($sinh(1.0)) = 0x3FF2CD9FC44EB982, OVERFLOW_OUT 0, READY in the same cycle.
- MODE=1/2/3, SIZE_IN=3, DATA_IN_ENABLE held high with inputs {0.0, 0.5, -2.0}:
  - results bit-exact against $cosh/$tanh/$exp;
  - pulses spaced exactly 2 cycles apart;
  - READY only on the third pulse;
  - cosh(0.0) = 0x3FF0000000000000.
- MODE=3 with 710.0, then MODE=0 with -800.0 → DATA_OUT 0x7FEFFFFFFFFFFFFF and 0xFFEFFFFFFFFFFFFF respectively, OVERFLOW_OUT 1. A following element of 0.0 clears OVERFLOW_OUT to 0.
- SIZE_IN=0 with START → no DATA_ENABLE, no DATA_OUT_ENABLE, READY one cycle after the START edge.
- START pulsed and MODE changed mid-run, plus DATA_IN_ENABLE asserted in STARTER_STATE and ENDER_STATE → all ignored; results follow the latched MODE and element count.
